// File: rtl/seven_seg_scan_driver.sv
// Multiplexed N-digit seven-segment scan driver with guard blanking.
// Define SEVSEG_LZB_EN to blank leading zero digits.
module seven_seg_scan_driver #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2,
  parameter int CNT_W       = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] bcd_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GD = CNT_W'(GUARD);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [4*N_DIGITS-1:0] bcd_q, bcd_d;
  logic [N_DIGITS-1:0]   dps_q, dps_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [N_DIGITS-1:0]   an_q, an_d;

  logic [N_DIGITS-1:0]   blank;
  logic [3:0]            nib;
  logic [6:0]            glyph;
  logic                  in_guard;
`ifdef SEVSEG_LZB_EN
  logic                  lz_seen;
`endif

  // Shadow capture, prescaler wrap and digit index advance
  always_comb begin
    bcd_d = load ? bcd_in : bcd_q;
    dps_d = load ? dp_in : dps_q;
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_TC) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) idx_d = '0;
      else idx_d = idx_q + 1'b1;
    end
  end

  // Leading-zero mask: digits above the top non-zero digit; digit 0 never
  always_comb begin
    blank = '0;
`ifdef SEVSEG_LZB_EN
    lz_seen = 1'b0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      if (bcd_q[4*k +: 4] != 4'd0) lz_seen = 1'b1;
      blank[k] = ~lz_seen;
    end
`endif
  end

  // BCD to active-low segments {g,f,e,d,c,b,a}; 10..15 show a dash
  always_comb begin
    nib = bcd_q[{idx_q, 2'b00} +: 4];
    unique case (nib)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b0111111;
    endcase
  end

  // Next registered outputs; everything dark during the guard interval
  always_comb begin
    in_guard = (cnt_q < CNT_GD);
    an_d     = '1;
    seg_d    = 7'b1111111;
    dp_d     = 1'b1;
    if (!in_guard) begin
      an_d[idx_q] = 1'b0;
      seg_d       = blank[idx_q] ? 7'b1111111 : glyph;
      dp_d        = ~dps_q[idx_q];
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q <= '0;
      dps_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      seg_q <= 7'b1111111;
      dp_q  <= 1'b1;
      an_q  <= '1;
    end else begin
      bcd_q <= bcd_d;
      dps_q <= dps_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule
